// File: rtl/mem_pkg.sv
// Shared types and helpers for the byte-enabled register-file memory bank.
// Holds the clear-sequencer state type and the byte-lane mask expansion.
package mem_pkg;

  typedef enum logic {ST_IDLE, ST_CLEAR} mem_state_t;

  // Widest supported word is MAX_NB bytes; callers truncate the result to their width.
  localparam int MAX_NB = 32;

  function automatic logic [MAX_NB*8-1:0] be_expand(input logic [MAX_NB-1:0] be);
    logic [MAX_NB*8-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_NB; i++) begin
      m[i*8 +: 8] = {8{be[i]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/mem_row_be.sv
// One flop-based memory row: async reset, synchronous clear and a per-bit
// write mask built from the byte enables.
module mem_row_be #(
  parameter int WIDTH = 16
) (
  input  logic             clkp,
  input  logic             rstp,
  input  logic             clr,
  input  logic             wen,
  input  logic [WIDTH-1:0] mask,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_r;

  // Row storage; clear has priority over a masked write.
  always_ff @(posedge clkp or posedge rstp) begin
    if (rstp) begin
      q_r <= '0;
    end else if (clr) begin
      q_r <= '0;
    end else if (wen) begin
      q_r <= (q_r & ~mask) | (din & mask);
    end else begin
      q_r <= q_r;
    end
  end

  assign q = q_r;

endmodule

// File: rtl/mem_bank_be.sv
// Single-port register-file memory with byte write enables, registered read
// with valid strobe, out-of-range error pulse and a hardware row-clear sequencer.
module mem_bank_be
  import mem_pkg::*;
#(
  parameter  int WIDTH = 16,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int NB    = WIDTH / 8
) (
  input  logic             clkp,
  input  logic             rstp,
  input  logic             cs,
  input  logic             we,
  input  logic [NB-1:0]    be,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             rvalid,
  output logic             err,
  input  logic             clr_req,
  output logic             busy
);

  mem_state_t       state_r;
  logic [AW-1:0]    ptr_r;
  logic [WIDTH-1:0] dout_r;
  logic             rvalid_r;
  logic             err_r;
  logic             busy_r;

  logic             in_range_s;
  logic             acc_s;
  logic [WIDTH-1:0] mask_s;
  logic [WIDTH-1:0] rd_data_s;
  logic [DEPTH-1:0] wen_s;
  logic [DEPTH-1:0] clr_row_s;
  logic [WIDTH-1:0] rows_s [DEPTH];

  // Extra top bit keeps the compare valid when DEPTH is a power of two.
  assign in_range_s = ({1'b0, addr} < (AW+1)'(DEPTH));
  assign acc_s      = (state_r == ST_IDLE) && cs && !clr_req;
  assign mask_s     = WIDTH'(be_expand(MAX_NB'(be)));

  for (genvar g = 0; g < DEPTH; g++) begin : g_row
    assign wen_s[g]     = acc_s && we && (addr == AW'(g));
    assign clr_row_s[g] = (state_r == ST_CLEAR) && (ptr_r == AW'(g));

    mem_row_be #(
      .WIDTH (WIDTH)
    ) u_row (
      .clkp (clkp),
      .rstp (rstp),
      .clr  (clr_row_s[g]),
      .wen  (wen_s[g]),
      .mask (mask_s),
      .din  (din),
      .q    (rows_s[g])
    );
  end

  // Read mux; an address matching no row yields zero.
  always_comb begin
    rd_data_s = '0;
    for (int i = 0; i < DEPTH; i++) begin
      rd_data_s = rd_data_s | ((addr == AW'(i)) ? rows_s[i] : '0);
    end
  end

  // Clear sequencer and registered read/err/busy outputs.
  always_ff @(posedge clkp or posedge rstp) begin
    if (rstp) begin
      state_r  <= ST_IDLE;
      ptr_r    <= '0;
      dout_r   <= '0;
      rvalid_r <= 1'b0;
      err_r    <= 1'b0;
      busy_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (clr_req) begin
            state_r  <= ST_CLEAR;
            ptr_r    <= '0;
            busy_r   <= 1'b1;
            rvalid_r <= 1'b0;
            err_r    <= 1'b0;
            dout_r   <= dout_r;
          end else begin
            state_r  <= ST_IDLE;
            ptr_r    <= ptr_r;
            busy_r   <= 1'b0;
            rvalid_r <= cs && !we;
            err_r    <= cs && !in_range_s;
            if (cs && !we) begin
              dout_r <= rd_data_s;
            end else begin
              dout_r <= dout_r;
            end
          end
        end
        ST_CLEAR: begin
          rvalid_r <= 1'b0;
          err_r    <= 1'b0;
          dout_r   <= dout_r;
          if (ptr_r == AW'(DEPTH-1)) begin
            state_r <= ST_IDLE;
            ptr_r   <= '0;
            busy_r  <= 1'b0;
          end else begin
            state_r <= ST_CLEAR;
            ptr_r   <= ptr_r + AW'(1);
            busy_r  <= 1'b1;
          end
        end
        default: begin
          state_r  <= ST_IDLE;
          ptr_r    <= '0;
          dout_r   <= dout_r;
          rvalid_r <= 1'b0;
          err_r    <= 1'b0;
          busy_r   <= 1'b0;
        end
      endcase
    end
  end

  assign dout   = dout_r;
  assign rvalid = rvalid_r;
  assign err    = err_r;
  assign busy   = busy_r;

endmodule

// File: tb/tb_mem_bank_be.sv
// Self-checking bench: a behavioural memory model checked every cycle against a
// 16x6 instance, plus literal checks and a 32x8 byte-lane instance.
module tb_mem_bank_be;

  logic        clkp = 1'b0;
  logic        rstp = 1'b1;

  logic        cs = 1'b0, we = 1'b0, clr_req = 1'b0;
  logic [1:0]  be = 2'b00;
  logic [2:0]  addr = 3'd0;
  logic [15:0] din = 16'h0000;
  logic [15:0] dout;
  logic        rvalid, err, busy;

  logic        c1_cs = 1'b0, c1_we = 1'b0, c1_clr = 1'b0;
  logic [3:0]  c1_be = 4'h0;
  logic [2:0]  c1_addr = 3'd0;
  logic [31:0] c1_din = 32'h0;
  logic [31:0] c1_dout;
  logic        c1_rvalid, c1_err, c1_busy;

  int checks = 0;
  int errors = 0;

  always #5 clkp = ~clkp;

  mem_bank_be #(.WIDTH(16), .DEPTH(6)) dut (
    .clkp(clkp), .rstp(rstp), .cs(cs), .we(we), .be(be), .addr(addr),
    .din(din), .dout(dout), .rvalid(rvalid), .err(err),
    .clr_req(clr_req), .busy(busy)
  );

  mem_bank_be #(.WIDTH(32), .DEPTH(8)) dut32 (
    .clkp(clkp), .rstp(rstp), .cs(c1_cs), .we(c1_we), .be(c1_be), .addr(c1_addr),
    .din(c1_din), .dout(c1_dout), .rvalid(c1_rvalid), .err(c1_err),
    .clr_req(c1_clr), .busy(c1_busy)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // ---------------- behavioural model of the 16x6 instance ----------------
  logic [15:0] m_mem [6];
  logic [15:0] e_dout;
  logic        e_rvalid, e_err;
  int          clr_left;

  task automatic m_reset();
    for (int i = 0; i < 6; i++) m_mem[i] = 16'h0000;
    e_dout = 16'h0000; e_rvalid = 1'b0; e_err = 1'b0; clr_left = 0;
  endtask

  task automatic m_step();
    e_rvalid = 1'b0;
    e_err    = 1'b0;
    if (clr_left > 0) begin
      m_mem[6 - clr_left] = 16'h0000;
      clr_left--;
    end else if (clr_req) begin
      clr_left = 6;
    end else if (cs) begin
      if (int'(addr) >= 6) begin
        e_err = 1'b1;
        if (!we) begin e_dout = 16'h0000; e_rvalid = 1'b1; end
      end else if (we) begin
        for (int b = 0; b < 2; b++)
          if (be[b]) m_mem[addr][8*b +: 8] = din[8*b +: 8];
      end else begin
        e_dout = m_mem[addr]; e_rvalid = 1'b1;
      end
    end
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clkp or posedge rstp);
      if (rstp) m_reset();
      else m_step();
    end
  end

  // Per-cycle comparison of all outputs against the model.
  initial begin
    forever begin
      @(negedge clkp);
      if (!rstp) begin
        chk("dout",   dout,   e_dout);
        chk("rvalid", rvalid, e_rvalid);
        chk("err",    err,    e_err);
        chk("busy",   busy,   clr_left > 0);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input logic c, input logic w, input logic [1:0] b,
                     input logic [2:0] a, input logic [15:0] d, input logic cl);
    @(negedge clkp);
    cs = c; we = w; be = b; addr = a; din = d; clr_req = cl;
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 2'b00, 3'd0, 16'h0000, 1'b0);
  endtask

  task automatic c1_cyc(input logic c, input logic w, input logic [3:0] b,
                        input logic [2:0] a, input logic [31:0] d);
    @(negedge clkp);
    c1_cs = c; c1_we = w; c1_be = b; c1_addr = a; c1_din = d; c1_clr = 1'b0;
  endtask

  int n;

  initial begin
    repeat (2) @(negedge clkp);
    rstp = 1'b0;

    // 1. reset state, read every row
    chk("rst_busy", busy, 1'b0);
    chk("rst_rvalid", rvalid, 1'b0);
    for (int a = 0; a < 6; a++) cyc(1'b1, 1'b0, 2'b11, 3'(a), 16'hFFFF, 1'b0);
    idle();
    chk("t1_rvalid", rvalid, 1'b1);
    chk("t1_dout", dout, 16'h0000);
    chk("t1_err", err, 1'b0);

    // 2. byte-lane merge
    cyc(1'b1, 1'b1, 2'b11, 3'd2, 16'hA5C3, 1'b0);
    cyc(1'b1, 1'b1, 2'b10, 3'd2, 16'h7700, 1'b0);
    cyc(1'b1, 1'b0, 2'b00, 3'd2, 16'h0000, 1'b0);
    idle();
    chk("t2_dout", dout, 16'h77C3);
    chk("t2_rvalid", rvalid, 1'b1);

    // 3. out-of-range write then read
    cyc(1'b1, 1'b1, 2'b11, 3'd6, 16'hFFFF, 1'b0);
    idle();
    chk("t3_wr_err", err, 1'b1);
    chk("t3_wr_rvalid", rvalid, 1'b0);
    cyc(1'b1, 1'b0, 2'b00, 3'd6, 16'h0000, 1'b0);
    idle();
    chk("t3_rd_err", err, 1'b1);
    chk("t3_rd_rvalid", rvalid, 1'b1);
    chk("t3_rd_dout", dout, 16'h0000);
    for (int a = 0; a < 6; a++) cyc(1'b1, 1'b0, 2'b00, 3'(a), 16'h0000, 1'b0);
    idle();

    // 4. fill, then clear with a colliding write that must be dropped
    for (int a = 0; a < 6; a++) cyc(1'b1, 1'b1, 2'b11, 3'(a), 16'(16'h1111 * (a + 1)), 1'b0);
    cyc(1'b1, 1'b0, 2'b00, 3'd4, 16'h0000, 1'b0);
    idle();
    chk("t4_fill", dout, 16'h5555);
    cyc(1'b1, 1'b1, 2'b11, 3'd0, 16'hBEEF, 1'b1);
    n = 0;
    repeat (20) begin
      idle();
      if (busy) n++;
    end
    chk("t4_busy_cycles", n, 6);
    for (int a = 0; a < 6; a++) begin
      cyc(1'b1, 1'b0, 2'b00, 3'(a), 16'h0000, 1'b0);
      idle();
      chk("t4_cleared", dout, 16'h0000);
    end

    // 5. asynchronous reset in the third CLEAR cycle
    for (int a = 0; a < 6; a++) cyc(1'b1, 1'b1, 2'b11, 3'(a), 16'hC0DE, 1'b0);
    cyc(1'b1, 1'b0, 2'b00, 3'd5, 16'h0000, 1'b0);
    cyc(1'b0, 1'b0, 2'b00, 3'd0, 16'h0000, 1'b1);
    idle();
    chk("t5_dout_before", dout, 16'hC0DE);
    @(posedge clkp);
    @(posedge clkp);
    #3 rstp = 1'b1;
    #1;
    chk("t5_busy", busy, 1'b0);
    chk("t5_dout", dout, 16'h0000);
    chk("t5_rvalid", rvalid, 1'b0);
    chk("t5_err", err, 1'b0);
    @(negedge clkp);
    rstp = 1'b0;
    for (int a = 0; a < 6; a++) begin
      cyc(1'b1, 1'b0, 2'b00, 3'(a), 16'h0000, 1'b0);
      idle();
      chk("t5_rows_zero", dout, 16'h0000);
    end

    // random traffic against the model
    repeat (600) begin
      cyc($urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)),
          3'($urandom_range(0, 7)), 16'($urandom), $urandom_range(0, 39) == 0);
    end
    repeat (10) idle();

    // 6. 32-bit lanes one at a time into the top row of the 8-deep instance
    for (int b = 0; b < 4; b++)
      c1_cyc(1'b1, 1'b1, 4'(1 << b), 3'd7, {4{8'(8'h11 * (b + 1))}});
    c1_cyc(1'b1, 1'b0, 4'h0, 3'd7, 32'h0);
    c1_cyc(1'b0, 1'b0, 4'h0, 3'd0, 32'h0);
    chk("t6_dout", c1_dout, 32'h44332211);
    chk("t6_rvalid", c1_rvalid, 1'b1);
    chk("t6_err", c1_err, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
